// File: rtl/dau_ascii_char_to_sym.sv
// ----------------------------------------------------------------------------
// dau_ascii_char_to_sym
// Receive-side translator: turns the ASCII byte stream from the UART RX into
// DAU symbols for the RPN core. Digits and the four operators map one-to-one.
// Whitespace runs collapse to a single SEPARATOR, and CR, LF and CRLF each
// collapse to one RESULT. Illegal bytes are dropped and flagged. Symbols are
// buffered in a first-word-fall-through FIFO because the UART cannot be
// stalled.
//
// Ports
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_char         ASCII byte from the UART RX
//   i_char_valid   one-cycle strobe qualifying i_char; there is no backpressure
//   o_sym          FIFO head symbol (0 while the FIFO is empty)
//   o_sym_valid    FIFO non-empty
//   i_sym_ready    the head is popped when o_sym_valid & i_sym_ready
//   o_invalid_char one-cycle pulse, the cycle after an illegal byte
//   o_overflow     sticky; a symbol was lost on a full FIFO; cleared by i_rst
// ----------------------------------------------------------------------------

`ifndef DAU_SYM_WIDTH
`define DAU_SYM_WIDTH     4
`define DAU_SYM_0         4'd0
`define DAU_SYM_1         4'd1
`define DAU_SYM_2         4'd2
`define DAU_SYM_3         4'd3
`define DAU_SYM_4         4'd4
`define DAU_SYM_5         4'd5
`define DAU_SYM_6         4'd6
`define DAU_SYM_7         4'd7
`define DAU_SYM_8         4'd8
`define DAU_SYM_9         4'd9
`define DAU_SYM_PLUS      4'd10
`define DAU_SYM_MINUS     4'd11
`define DAU_SYM_MUL       4'd12
`define DAU_SYM_DIV       4'd13
`define DAU_SYM_SEPARATOR 4'd14
`define DAU_SYM_RESULT    4'd15
`endif

module dau_ascii_char_to_sym #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [7:0]                i_char,
  input  logic                      i_char_valid,
  output logic [`DAU_SYM_WIDTH-1:0] o_sym,
  output logic                      o_sym_valid,
  input  logic                      i_sym_ready,
  output logic                      o_invalid_char,
  output logic                      o_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_TOKEN = 2'd1,
    S_SEP   = 2'd2,
    S_CR    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    C_SYM     = 3'd0,
    C_WS      = 3'd1,
    C_CR      = 3'd2,
    C_LF      = 3'd3,
    C_INVALID = 3'd4
  } char_class_t;

  // Byte classification; digits and operators share one class.
  function automatic char_class_t classify(input logic [7:0] c);
    char_class_t k;
    case (c)
      8'h30, 8'h31, 8'h32, 8'h33, 8'h34,
      8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
      8'h2B, 8'h2D, 8'h2A, 8'h2F: k = C_SYM;
      8'h20, 8'h09:               k = C_WS;
      8'h0D:                      k = C_CR;
      8'h0A:                      k = C_LF;
      default:                    k = C_INVALID;
    endcase
    return k;
  endfunction

  // Symbol for a byte of class C_SYM.
  function automatic logic [`DAU_SYM_WIDTH-1:0] map_sym(input logic [7:0] c);
    logic [`DAU_SYM_WIDTH-1:0] s;
    case (c)
      8'h30:   s = `DAU_SYM_0;
      8'h31:   s = `DAU_SYM_1;
      8'h32:   s = `DAU_SYM_2;
      8'h33:   s = `DAU_SYM_3;
      8'h34:   s = `DAU_SYM_4;
      8'h35:   s = `DAU_SYM_5;
      8'h36:   s = `DAU_SYM_6;
      8'h37:   s = `DAU_SYM_7;
      8'h38:   s = `DAU_SYM_8;
      8'h39:   s = `DAU_SYM_9;
      8'h2B:   s = `DAU_SYM_PLUS;
      8'h2D:   s = `DAU_SYM_MINUS;
      8'h2A:   s = `DAU_SYM_MUL;
      8'h2F:   s = `DAU_SYM_DIV;
      default: s = `DAU_SYM_0;
    endcase
    return s;
  endfunction

  state_t                    r_state;
  state_t                    w_next_state;
  logic                      w_push;
  logic [`DAU_SYM_WIDTH-1:0] w_push_sym;
  logic                      w_invalid;

  logic [`DAU_SYM_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [CNT_W-1:0]          r_count;
  logic                      r_invalid;
  logic                      r_overflow;

  logic                      w_empty;
  logic                      w_full;
  logic                      w_pop;
  logic                      w_wr;

  // Next-state and push decision for the tokenizer.
  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    w_push_sym   = `DAU_SYM_0;
    w_invalid    = 1'b0;
    if (i_char_valid) begin
      case (classify(i_char))
        C_SYM: begin
          w_push       = 1'b1;
          w_push_sym   = map_sym(i_char);
          w_next_state = S_TOKEN;
        end
        C_WS: begin
          // Only the first blank after a token is significant.
          case (r_state)
            S_TOKEN: begin
              w_push       = 1'b1;
              w_push_sym   = `DAU_SYM_SEPARATOR;
              w_next_state = S_SEP;
            end
            S_CR:    w_next_state = S_START;
            default: w_next_state = r_state;
          endcase
        end
        C_CR: begin
          w_push       = 1'b1;
          w_push_sym   = `DAU_SYM_RESULT;
          w_next_state = S_CR;
        end
        C_LF: begin
          // LF right after CR completes a CRLF pair that already emitted RESULT.
          if (r_state == S_CR) begin
            w_next_state = S_START;
          end else begin
            w_push       = 1'b1;
            w_push_sym   = `DAU_SYM_RESULT;
            w_next_state = S_START;
          end
        end
        default: begin
          w_invalid = 1'b1;
          if (r_state == S_CR) begin
            w_next_state = S_START;
          end else begin
            w_next_state = r_state;
          end
        end
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  assign w_empty = (r_count == {CNT_W{1'b0}});
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop   = i_sym_ready & ~w_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr    = w_push & (~w_full | w_pop);

  // Tokenizer state, FIFO pointers/count and status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_START;
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_invalid  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_invalid <= w_invalid;
      if (w_push & ~w_wr) begin
        r_overflow <= 1'b1;
      end
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr) begin
      r_mem[r_wr_ptr] <= w_push_sym;
    end
  end

  // The head is masked to 0 while empty so stale entries never show.
  assign o_sym          = w_empty ? `DAU_SYM_0 : r_mem[r_rd_ptr];
  assign o_sym_valid    = ~w_empty;
  assign o_invalid_char = r_invalid;
  assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_dau_ascii_char_to_sym.sv
// ----------------------------------------------------------------------------
// tb_dau_ascii_char_to_sym
// Directed bench for dau_ascii_char_to_sym. Inputs change 1 ns after the
// rising edge; outputs are observed on the falling edge, where every pop and
// every o_invalid_char pulse is logged for later comparison.
// ----------------------------------------------------------------------------
module tb_dau_ascii_char_to_sym;

  localparam int PLUS = 10;
  localparam int MINUS = 11;
  localparam int MUL = 12;
  localparam int DIV = 13;
  localparam int SEP = 14;
  localparam int RES = 15;

  logic       clk;
  logic       i_rst;
  logic [7:0] i_char;
  logic       i_char_valid;
  logic [3:0] o_sym;
  logic       o_sym_valid;
  logic       i_sym_ready;
  logic       o_invalid_char;
  logic       o_overflow;

  int test_cnt = 0;
  int fail_cnt = 0;
  int cyc = 0;
  int got[$];
  int inv_cnt = 0;
  int inv_cyc = -1;
  int a_cyc = -1;

  dau_ascii_char_to_sym #(.FIFO_DEPTH(8)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_char         (i_char),
    .i_char_valid   (i_char_valid),
    .o_sym          (o_sym),
    .o_sym_valid    (o_sym_valid),
    .i_sym_ready    (i_sym_ready),
    .o_invalid_char (o_invalid_char),
    .o_overflow     (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log popped symbols and invalid-char pulses mid-cycle.
  always @(negedge clk) begin
    if (o_sym_valid && i_sym_ready) got.push_back(int'(o_sym));
    if (o_invalid_char) begin
      inv_cnt = inv_cnt + 1;
      inv_cyc = cyc;
    end
  end

  task automatic chk_eq(input string tag, input int obs, input int exp);
    test_cnt = test_cnt + 1;
    if (obs !== exp) begin
      fail_cnt = fail_cnt + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int exp[$]);
    chk_eq($sformatf("%s_len", tag), got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      chk_eq($sformatf("%s_sym%0d", tag, i), (i < got.size()) ? got[i] : -1, exp[i]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    i_char = b;
    i_char_valid = 1'b1;
    if (b == 8'h61) a_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      i_char_valid = 1'b0;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    idle(1);
  endtask

  initial begin
    i_rst = 1'b1;
    i_char = 8'h00;
    i_char_valid = 1'b0;
    i_sym_ready = 1'b0;
    idle(2);
    chk_eq("rst_valid", int'(o_sym_valid), 0);
    chk_eq("rst_sym", int'(o_sym), 0);
    chk_eq("rst_ovf", int'(o_overflow), 0);
    chk_eq("rst_inv", int'(o_invalid_char), 0);
    i_rst = 1'b0;
    i_sym_ready = 1'b1;

    // "12 +3\r\n"
    got.delete();
    send_str("12 +3\015\012");
    idle(4);
    check_seq("t1", '{1, 2, SEP, PLUS, 3, RES});
    chk_eq("t1_ovf", int'(o_overflow), 0);

    // "  7   8\t\t*\n"
    got.delete();
    send_str("  7   8\011\011*\012");
    idle(4);
    check_seq("t2", '{7, SEP, 8, SEP, MUL, RES});

    // "\r\r\n4"
    got.delete();
    send_str("\015\015\0124");
    idle(4);
    check_seq("t3", '{RES, RES, 4});

    // remaining operators
    got.delete();
    send_str("9-/\012");
    idle(4);
    check_seq("t3b", '{9, MINUS, DIV, RES});

    // "5a6"
    got.delete();
    inv_cnt = 0;
    send_str("5a6");
    idle(4);
    check_seq("t4", '{5, 6});
    chk_eq("t4_inv_cnt", inv_cnt, 1);
    chk_eq("t4_inv_cyc", inv_cyc, a_cyc + 1);

    // Overflow: ten digits into an 8-deep FIFO that is not being drained.
    i_sym_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i > 0) chk_eq($sformatf("t5_ovf_after%0d", i), int'(o_overflow), (i - 1 >= 8) ? 1 : 0);
      i_char = 8'h30 + 8'(i);
      i_char_valid = 1'b1;
    end
    @(posedge clk); #1;
    i_char_valid = 1'b0;
    chk_eq("t5_ovf_after10", int'(o_overflow), 1);
    chk_eq("t5_head", int'(o_sym), 0);
    chk_eq("t5_valid", int'(o_sym_valid), 1);
    i_sym_ready = 1'b1;
    idle(10);
    check_seq("t5", '{0, 1, 2, 3, 4, 5, 6, 7});
    chk_eq("t5_ovf_sticky", int'(o_overflow), 1);
    chk_eq("t5_empty", int'(o_sym_valid), 0);

    // Reset clears overflow; a strobe during reset is ignored.
    i_sym_ready = 1'b0;
    @(posedge clk); #1;
    i_rst = 1'b1;
    i_char = 8'h35;
    i_char_valid = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    i_char_valid = 1'b0;
    chk_eq("t6_rst_ovf", int'(o_overflow), 0);
    chk_eq("t6_rst_valid", int'(o_sym_valid), 0);

    // Full FIFO plus push with simultaneous pop.
    got.delete();
    send_str("12345678");
    chk_eq("t6_full_head", int'(o_sym), 1);
    @(posedge clk); #1;
    i_char = 8'h39;
    i_char_valid = 1'b1;
    i_sym_ready = 1'b1;
    @(posedge clk); #1;
    i_char_valid = 1'b0;
    i_sym_ready = 1'b0;
    chk_eq("t6_ovf", int'(o_overflow), 0);
    chk_eq("t6_head", int'(o_sym), 2);
    i_sym_ready = 1'b1;
    idle(12);
    check_seq("t6", '{1, 2, 3, 4, 5, 6, 7, 8, 9});

    // Mid-stream reset discards FIFO and tokenizer state.
    i_sym_ready = 1'b0;
    got.delete();
    send_str("12");
    chk_eq("t6_pre_valid", int'(o_sym_valid), 1);
    @(posedge clk); #1;
    i_rst = 1'b1;
    i_char = 8'h35;
    i_char_valid = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    i_char_valid = 1'b0;
    chk_eq("t6_mid_rst_valid", int'(o_sym_valid), 0);
    send_str(" 9");
    i_sym_ready = 1'b1;
    idle(4);
    check_seq("t6_post", '{9});
    chk_eq("t6_post_ovf", int'(o_overflow), 0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
